ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/eater_pkg.sv | 24 ++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// ============================================================================
//  eater_pkg
//  Shared types and sizing constants for the RAM ownership arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package eater_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 16;
    localparam int CNT_W     = $clog2(RAM_DEPTH) + 1;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  ram_arbiter
//  Hands a single-port RAM between the CPU and a bulk loader, freezing the
//  CPU at microcode step T0 before the loader is granted.
//  Optional readback path enabled by macro RAM_ARB_READBACK_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
    import eater_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] cpu_mar,
    input  logic              cpu_ri,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_boundary,
    output logic              cpu_hold,
    input  logic              ld_req,
    output logic              ld_grant,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic [CNT_W-1:0]  ld_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAM_DEPTH);

    arb_state_t state;
    logic       rd_block;
    logic       wr_acc;
    logic       rd_acc;

    assign ld_ready = (state == LOAD) && !rd_block;
    assign wr_acc   = ld_valid && ld_ready && ld_we;
    assign rd_acc   = ld_valid && ld_ready && !ld_we;

    always_comb begin
        ram_addr  = cpu_mar;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        cpu_hold  = 1'b0;
        ld_grant  = 1'b0;
        case (state)
            CPU_OWN: ram_we = cpu_ri;
            DRAIN: begin
                // A CPU frozen at T0 must not write during the hand-over edge
                ram_we   = cpu_ri && !cpu_boundary;
                cpu_hold = cpu_boundary;
            end
            LOAD: begin
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
                ram_we    = wr_acc;
                cpu_hold  = 1'b1;
                ld_grant  = 1'b1;
            end
            RELEASE: cpu_hold = 1'b1;
            default: ram_we = 1'b0;
        endcase
        if (!clr_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= CPU_OWN;
            ld_count <= '0;
            rd_block <= 1'b0;
        end else begin
            rd_block <= rd_acc;
            case (state)
                CPU_OWN: if (ld_req) state <= DRAIN;
                DRAIN: begin
                    if (!ld_req) begin
                        state <= CPU_OWN;
                    end else if (cpu_boundary) begin
                        state    <= LOAD;
                        ld_count <= '0;
                    end
                end
                LOAD: begin
                    if (wr_acc && (ld_count != CNT_MAX)) begin
                        ld_count <= ld_count + 1'b1;
                    end
                    if (!ld_req) state <= RELEASE;
                end
                RELEASE: state <= CPU_OWN;
                default: state <= CPU_OWN;
            endcase
        end
    end

`ifdef RAM_ARB_READBACK_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_rvalid <= rd_acc;
            if (rd_acc) ld_rdata <= ram_rdata;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign ld_rvalid    = 1'b0;
    assign ld_rdata     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  tb_ram_arbiter
//  Directed and randomized checks of ram_arbiter against a cycle model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

`ifdef RAM_ARB_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] cpu_mar;
    logic       cpu_ri;
    logic [7:0] cpu_wdata;
    logic       cpu_boundary;
    logic       cpu_hold;
    logic       ld_req;
    logic       ld_grant;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic [7:0] ld_rdata;
    logic       ld_rvalid;
    logic [4:0] ld_count;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    ram_arbiter dut (
        .clk(clk), .clr_n(clr_n),
        .cpu_mar(cpu_mar), .cpu_ri(cpu_ri), .cpu_wdata(cpu_wdata),
        .cpu_boundary(cpu_boundary), .cpu_hold(cpu_hold),
        .ld_req(ld_req), .ld_grant(ld_grant), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .ld_count(ld_count), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM attached to the arbiter
    logic [7:0] mem [16];
    int         we_pulses = 0;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_pulses++;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the RAM, how many writes, pending readback
    int         owner;      // 0 cpu, 1 waiting for T0, 2 loader, 3 handing back
    int         wcount;
    bit         rpend;
    logic [7:0] rval;
    logic [7:0] mm [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        wcount = 0;
        rpend  = 1'b0;
        rval   = 8'h00;
    endtask

    task automatic tick();
        logic       e_hold, e_grant, e_ready, e_we, rd;
        logic [3:0] e_addr;
        logic [7:0] e_wdata;
        #2;
        e_hold  = (owner == 0) ? 1'b0 : (owner == 1) ? cpu_boundary : 1'b1;
        e_grant = (owner == 2);
        e_ready = (owner == 2) && !rpend;
        e_addr  = (owner == 2) ? ld_addr : cpu_mar;
        e_wdata = (owner == 2) ? ld_wdata : cpu_wdata;
        case (owner)
            0:       e_we = cpu_ri;
            1:       e_we = cpu_ri && !cpu_boundary;
            2:       e_we = ld_valid && e_ready && ld_we;
            default: e_we = 1'b0;
        endcase
        check("cpu_hold",  cpu_hold,  e_hold);
        check("ld_grant",  ld_grant,  e_grant);
        check("ld_ready",  ld_ready,  e_ready);
        check("ram_we",    ram_we,    e_we);
        check("ram_addr",  ram_addr,  e_addr);
        check("ram_wdata", ram_wdata, e_wdata);
        check("ld_count",  ld_count,  wcount);
        check("ld_rvalid", ld_rvalid, RB && rpend);
        check("ld_rdata",  ld_rdata,  RB ? rval : 8'h00);
        @(posedge clk);
        rd = (owner == 2) && ld_valid && e_ready && !ld_we;
        if (RB && rd) rval = mm[ld_addr];
        rpend = rd;
        if (e_we) mm[e_addr] = e_wdata;
        if (owner == 2 && e_we && wcount < 16) wcount++;
        case (owner)
            0: if (ld_req) owner = 1;
            1: begin
                if (!ld_req) owner = 0;
                else if (cpu_boundary) begin
                    owner  = 2;
                    wcount = 0;
                end
            end
            2: if (!ld_req) owner = 3;
            default: owner = 0;
        endcase
        #1;
    endtask

    initial begin
        int snap;
        clr_n = 1'b0;
        cpu_mar = 4'd0; cpu_ri = 1'b0; cpu_wdata = 8'h00; cpu_boundary = 1'b0;
        ld_req = 1'b0; ld_valid = 1'b0; ld_we = 1'b0; ld_addr = 4'd0; ld_wdata = 8'h00;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'(i * 3);
            mm[i]  = 8'(i * 3);
        end
        model_reset();
        #12;
        check("rst_hold",   cpu_hold,  1'b0);
        check("rst_grant",  ld_grant,  1'b0);
        check("rst_ready",  ld_ready,  1'b0);
        check("rst_rvalid", ld_rvalid, 1'b0);
        check("rst_rdata",  ld_rdata,  8'h00);
        check("rst_count",  ld_count,  5'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // CPU owns the RAM
        cpu_mar = 4'd5; cpu_ri = 1'b1; cpu_wdata = 8'h3C;
        #1;
        check("cpu_addr",  ram_addr,  4'd5);
        check("cpu_we",    ram_we,    1'b1);
        check("cpu_wdata", ram_wdata, 8'h3C);
        check("cpu_hold0", cpu_hold,  1'b0);
        tick();
        cpu_ri = 1'b0;

        // Loader waits for the CPU to reach T0
        ld_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain_hold0", cpu_hold, 1'b0);
            tick();
        end
        cpu_boundary = 1'b1;
        #1;
        check("drain_hold1", cpu_hold, 1'b1);
        tick();
        cpu_boundary = 1'b0;
        #1;
        check("grant_after_t0", ld_grant, 1'b1);

        // Bulk load, then one write past saturation
        snap = we_pulses;
        for (int a = 0; a < 16; a++) begin
            ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'(a); ld_wdata = 8'hA0 + 8'(a);
            tick();
        end
        ld_valid = 1'b0;
        #1;
        check("bulk_pulses", we_pulses - snap, 16);
        check("bulk_count",  ld_count, 5'd16);
        check("bulk_mem0",   mem[0],  8'hA0);
        check("bulk_mem15",  mem[15], 8'hAF);
        ld_valid = 1'b1; ld_addr = 4'd7; ld_wdata = 8'h5E;
        tick();
        ld_valid = 1'b0;
        #1;
        check("sat_count", ld_count, 5'd16);

        // Readback of address 7
        ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'd7;
        #1;
        check("rd_ready", ld_ready, 1'b1);
        tick();
        ld_valid = 1'b0;
        #1;
        check("rd_rvalid", ld_rvalid, RB);
        check("rd_rdata",  ld_rdata,  RB ? 8'h5E : 8'h00);
        check("rd_stall",  ld_ready,  1'b0);
        tick();
        #1;
        check("rd_rvalid_end", ld_rvalid, 1'b0);
        check("rd_ready_back", ld_ready,  1'b1);

        // Release with a write in the final cycle
        snap = we_pulses;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'd9; ld_wdata = 8'h99; ld_req = 1'b0;
        tick();
        ld_valid = 1'b0; cpu_ri = 1'b1;
        #1;
        check("rel_last_write", we_pulses - snap, 1);
        check("rel_mem9",  mem[9],   8'h99);
        check("rel_grant", ld_grant, 1'b0);
        check("rel_hold",  cpu_hold, 1'b1);
        check("rel_we",    ram_we,   1'b0);
        tick();
        #1;
        check("rel_cpu_back", cpu_hold, 1'b0);
        cpu_ri = 1'b0;

        // Reset in the middle of a load
        ld_req = 1'b1; cpu_boundary = 1'b1;
        tick();
        tick();
        cpu_boundary = 1'b0;
        for (int a = 0; a < 4; a++) begin
            ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'(a + 2); ld_wdata = 8'h40 + 8'(a);
            tick();
        end
        cpu_ri = 1'b1;
        #2;
        clr_n = 1'b0;
        #1;
        check("mrst_hold",  cpu_hold, 1'b0);
        check("mrst_grant", ld_grant, 1'b0);
        check("mrst_count", ld_count, 5'd0);
        check("mrst_we",    ram_we,   1'b0);
        check("mrst_ready", ld_ready, 1'b0);
        model_reset();
        snap = we_pulses;
        @(posedge clk); #1;
        check("mrst_no_pulse", we_pulses - snap, 0);
        clr_n = 1'b1; ld_req = 1'b0; ld_valid = 1'b0; cpu_ri = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0) ld_req = !ld_req;
            cpu_boundary = ($urandom_range(3) == 0);
            cpu_mar   = 4'($urandom);
            cpu_ri    = 1'($urandom);
            cpu_wdata = 8'($urandom);
            ld_valid  = 1'($urandom);
            ld_we     = 1'($urandom);
            ld_addr   = 4'($urandom);
            ld_wdata  = 8'($urandom);
            tick();
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], mm[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
